cheshire_eoc_monitor: RTL and testbench

Synthesizable multi-channel end-of-computation (EOC) monitor for the Cheshire SoC. It observes register-bus writes to a bank of scratch registers and detects per-channel EOC writes (bit 0 set), capturing the return code. Each channel has an optional cycle timeout. It aggregates pass/fail for the test harness or an on-chip supervisor, replacing host-side JTAG polling of a single scratch register.

---
 rtl/cheshire_eoc_pkg.sv | 15 +
 rtl/cheshire_eoc_channel.sv | 56 +++++
 rtl/cheshire_eoc_monitor.sv | 89 ++++++++
 tb/tb_cheshire_eoc_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cheshire_eoc_pkg.sv
// Shared types and defaults for the Cheshire end-of-computation monitor.
// Channel states are exported on state_o using these exact 2-bit encodings.
package cheshire_eoc_pkg;

    typedef enum logic [1:0] {
        EOC_IDLE    = 2'd0,
        EOC_ARMED   = 2'd1,
        EOC_DONE    = 2'd2,
        EOC_TIMEOUT = 2'd3
    } eoc_state_e;

    localparam logic [47:0] DefaultBaseAddr   = 48'h0_0200_4004;
    localparam int unsigned DefaultChanStride = 4;

endpackage

// File: rtl/cheshire_eoc_channel.sv
// One EOC channel: state FSM, timeout counter, exit-code capture, leave-ARMED strobe.
// State/exit code update on the sampling edge; strobe is registered; no backpressure.
module cheshire_eoc_channel
    import cheshire_eoc_pkg::*;
#(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned TimeoutWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    arm_i,
    input  logic                    clear_i,
    input  logic                    hit_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [TimeoutWidth-1:0] timeout_i,
    output eoc_state_e              state_o,
    output logic [DataWidth-2:0]    exit_code_o,
    output logic                    leave_o
);

    logic [TimeoutWidth-1:0] cnt;

    // Priority: clear > arm > EOC hit > expiry. A zero counter never expires.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_o     <= EOC_IDLE;
            cnt         <= '0;
            exit_code_o <= '0;
            leave_o     <= 1'b0;
        end else begin
            leave_o <= 1'b0;
            if (clear_i) begin
                state_o <= EOC_IDLE;
                cnt     <= '0;
            end else if (arm_i) begin
                state_o     <= EOC_ARMED;
                cnt         <= timeout_i;
                exit_code_o <= '0;
            end else if (state_o == EOC_ARMED) begin
                if (hit_i && wdata_i[0]) begin
                    state_o     <= EOC_DONE;
                    exit_code_o <= wdata_i[DataWidth-1:1];
                    cnt         <= '0;
                    leave_o     <= 1'b1;
                end else if (cnt == TimeoutWidth'(1)) begin
                    state_o <= EOC_TIMEOUT;
                    cnt     <= '0;
                    leave_o <= 1'b1;
                end else if (cnt != '0) begin
                    cnt <= cnt - TimeoutWidth'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cheshire_eoc_monitor.sv
// Multi-channel EOC monitor snooping register-bus writes; all outputs registered.
// Observe-only: accepts one beat per cycle, never stalls the bus.
module cheshire_eoc_monitor
    import cheshire_eoc_pkg::*;
#(
    parameter int unsigned          NumChannels  = 4,
    parameter int unsigned          AddrWidth    = 48,
    parameter int unsigned          DataWidth    = 32,
    parameter logic [AddrWidth-1:0] BaseAddr     = AddrWidth'(DefaultBaseAddr),
    parameter int unsigned          ChanStride   = DefaultChanStride,
    parameter int unsigned          TimeoutWidth = 32
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 mon_valid_i,
    input  logic                                 mon_write_i,
    input  logic [AddrWidth-1:0]                 mon_addr_i,
    input  logic [DataWidth-1:0]                 mon_wdata_i,
    input  logic [NumChannels-1:0]               arm_i,
    input  logic [TimeoutWidth-1:0]              timeout_i,
    input  logic [NumChannels-1:0]               clear_i,
    output logic [2*NumChannels-1:0]             state_o,
    output logic [(DataWidth-1)*NumChannels-1:0] exit_code_o,
    output logic                                 all_done_o,
    output logic                                 any_fail_o,
    output logic                                 irq_o
);

    logic [NumChannels-1:0] hit;
    logic [NumChannels-1:0] leave;
    eoc_state_e             state     [NumChannels];
    logic [DataWidth-2:0]   exit_code [NumChannels];

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        localparam logic [AddrWidth-1:0] ChanAddr = BaseAddr + AddrWidth'(c * ChanStride);

        // Exact match only: unaligned or out-of-range beats fall through.
        assign hit[c] = mon_valid_i & mon_write_i & (mon_addr_i == ChanAddr);

        cheshire_eoc_channel #(
            .DataWidth    (DataWidth),
            .TimeoutWidth (TimeoutWidth)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .arm_i       (arm_i[c]),
            .clear_i     (clear_i[c]),
            .hit_i       (hit[c]),
            .wdata_i     (mon_wdata_i),
            .timeout_i   (timeout_i),
            .state_o     (state[c]),
            .exit_code_o (exit_code[c]),
            .leave_o     (leave[c])
        );

        assign state_o[2*c +: 2]                           = state[c];
        assign exit_code_o[(DataWidth-1)*c +: DataWidth-1] = exit_code[c];
    end

    logic any_armed;
    logic any_finished;
    logic any_bad;

    always_comb begin
        any_armed    = 1'b0;
        any_finished = 1'b0;
        any_bad      = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            if (state[c] == EOC_ARMED) any_armed = 1'b1;
            if (state[c] == EOC_DONE || state[c] == EOC_TIMEOUT) any_finished = 1'b1;
            if (state[c] == EOC_TIMEOUT) any_bad = 1'b1;
            if (state[c] == EOC_DONE && exit_code[c] != '0) any_bad = 1'b1;
        end
    end

    // Simultaneous completions collapse into a single irq pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            all_done_o <= 1'b0;
            any_fail_o <= 1'b0;
            irq_o      <= 1'b0;
        end else begin
            all_done_o <= ~any_armed & any_finished;
            any_fail_o <= any_bad;
            irq_o      <= |leave;
        end
    end

endmodule

// File: tb/tb_cheshire_eoc_monitor.sv
// Scoreboard bench: per-edge expectations from an event/deadline reference model,
// compared by an independent negedge monitor; plus directed spot checks.
module tb_cheshire_eoc_monitor;

    localparam int NC = 4;
    localparam int AW = 48;
    localparam int DW = 32;
    localparam int TW = 32;
    localparam logic [AW-1:0] BASE = 48'h0_0200_4004;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 mon_valid = 1'b0;
    logic                 mon_write = 1'b0;
    logic [AW-1:0]        mon_addr = '0;
    logic [DW-1:0]        mon_wdata = '0;
    logic [NC-1:0]        arm = '0;
    logic [TW-1:0]        tmo = '0;
    logic [NC-1:0]        clr = '0;
    logic [2*NC-1:0]      state;
    logic [(DW-1)*NC-1:0] exit_code;
    logic                 all_done;
    logic                 any_fail;
    logic                 irq;

    cheshire_eoc_monitor dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mon_valid_i (mon_valid),
        .mon_write_i (mon_write),
        .mon_addr_i  (mon_addr),
        .mon_wdata_i (mon_wdata),
        .arm_i       (arm),
        .timeout_i   (tmo),
        .clear_i     (clr),
        .state_o     (state),
        .exit_code_o (exit_code),
        .all_done_o  (all_done),
        .any_fail_o  (any_fail),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2*NC-1:0]      st;
        logic [(DW-1)*NC-1:0] ex;
        logic                 ad;
        logic                 af;
        logic                 irq;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: states 0..3, exit codes, absolute expiry deadline (-1 = none).
    int            m_st [NC];
    logic [DW-2:0] m_ex [NC];
    longint        m_dl [NC];
    longint        cyc = 0;
    logic          p_ad = 1'b0, p_af = 1'b0, p_irq = 1'b0;

    task automatic model_edge();
        exp_t          e;
        logic          left;
        logic          ad, af, armed_any, fin_any;
        logic [AW-1:0] a;
        left = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (rst) begin
                m_st[c] = 0; m_ex[c] = '0; m_dl[c] = -1;
            end else begin
                a = BASE + AW'(c * 4);
                if (clr[c]) m_st[c] = 0;
                else if (arm[c]) begin
                    m_st[c] = 1; m_ex[c] = '0;
                    m_dl[c] = (tmo == 0) ? -1 : cyc + longint'(tmo);
                end else if (m_st[c] == 1) begin
                    if (mon_valid && mon_write && mon_addr == a && mon_wdata[0]) begin
                        m_st[c] = 2; m_ex[c] = mon_wdata[DW-1:1]; left = 1'b1;
                    end else if (m_dl[c] == cyc) begin
                        m_st[c] = 3; left = 1'b1;
                    end
                end
            end
            e.st[2*c +: 2]       = 2'(m_st[c]);
            e.ex[(DW-1)*c +: DW-1] = m_ex[c];
        end
        e.ad  = rst ? 1'b0 : p_ad;
        e.af  = rst ? 1'b0 : p_af;
        e.irq = rst ? 1'b0 : p_irq;
        sb.push_back(e);
        armed_any = 1'b0; fin_any = 1'b0; af = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (m_st[c] == 1) armed_any = 1'b1;
            if (m_st[c] >= 2) fin_any = 1'b1;
            if (m_st[c] == 3 || (m_st[c] == 2 && m_ex[c] != 0)) af = 1'b1;
        end
        ad    = !armed_any && fin_any;
        p_ad  = rst ? 1'b0 : ad;
        p_af  = rst ? 1'b0 : af;
        p_irq = rst ? 1'b0 : left;
        cyc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("state_o", 128'(state), 128'(e.st));
            check("exit_code_o", 128'(exit_code), 128'(e.ex));
            check("all_done_o", 128'(all_done), 128'(e.ad));
            check("any_fail_o", 128'(any_fail), 128'(e.af));
            check("irq_o", 128'(irq), 128'(e.irq));
        end
    end

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b0; arm = '0; clr = '0; mon_valid = 1'b0; mon_write = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat(input logic wr, input logic [AW-1:0] ad, input logic [DW-1:0] d);
        mon_valid = 1'b1; mon_write = wr; mon_addr = ad; mon_wdata = d;
        step();
    endtask

    function automatic logic [DW-2:0] ch_ex(input int c);
        logic [(DW-1)*NC-1:0] v;
        v = exit_code;
        return v[(DW-1)*c +: DW-1];
    endfunction

    function automatic logic [1:0] ch_st(input int c);
        logic [2*NC-1:0] v;
        v = state;
        return v[2*c +: 2];
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin rst = 1'b1; step(); end
        check("reset_state", 128'(state), 128'(0));
        check("reset_irq", 128'(irq), 128'(0));

        // Pass on ch0, no timeout
        tmo = 0; arm = 4'b0001; step();
        beat(1'b1, BASE, 32'h1);
        check("pass_state", 128'(ch_st(0)), 128'(2));
        step();
        check("pass_all_done", 128'(all_done), 128'(1));
        check("pass_irq", 128'(irq), 128'(1));
        check("pass_any_fail", 128'(any_fail), 128'(0));
        idle(2);

        // Nonzero exit code on ch2
        arm = 4'b0100; step();
        beat(1'b1, BASE + 48'd8, 32'h55);
        check("fail_code", 128'(ch_ex(2)), 128'(31'h2A));
        step();
        check("fail_any_fail", 128'(any_fail), 128'(1));

        // Timeout on ch1 after exactly 10 edges, then a hit on the expiry edge
        clr = 4'hF; step();
        tmo = 10; arm = 4'b0010; step();
        idle(9);
        check("tmo_before", 128'(ch_st(1)), 128'(1));
        step();
        check("tmo_expired", 128'(ch_st(1)), 128'(3));
        step();
        check("tmo_irq", 128'(irq), 128'(1));
        arm = 4'b0010; step();
        idle(9);
        beat(1'b1, BASE + 48'd4, 32'h1);
        check("tmo_hit_wins", 128'(ch_st(1)), 128'(2));

        // Ignored beats on armed ch0
        tmo = 0; arm = 4'b0001; step();
        beat(1'b1, BASE, 32'h2);
        beat(1'b1, BASE + 48'd1, 32'h3);
        beat(1'b1, BASE + 48'h10, 32'h3);
        beat(1'b0, BASE, 32'h1);
        check("ignored_state", 128'(ch_st(0)), 128'(1));
        check("ignored_exit", 128'(ch_ex(0)), 128'(0));

        // Priority and first-EOC-wins
        clr = 4'b1000; arm = 4'b1000; step();
        check("clear_over_arm", 128'(ch_st(3)), 128'(0));
        beat(1'b1, BASE, 32'h5);
        beat(1'b1, BASE, 32'h7);
        check("first_wins", 128'(ch_ex(0)), 128'(2));
        arm = 4'b0001; step();
        check("rearm_exit", 128'(ch_ex(0)), 128'(0));
        arm = 4'b0001; beat(1'b1, BASE, 32'h3);
        check("arm_over_hit", 128'(ch_st(0)), 128'(1));

        // All four channels expire together
        clr = 4'hF; step();
        tmo = 5; arm = 4'hF; step();
        idle(8);

        // Reset in the middle of a timeout
        tmo = 20; arm = 4'hF; step();
        idle(5);
        rst = 1'b1; step();
        check("midreset_state", 128'(state), 128'(0));
        idle(25);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            for (int c = 0; c < NC; c++) begin
                arm[c] = ($urandom_range(0, 19) == 0);
                clr[c] = ($urandom_range(0, 39) == 0);
            end
            tmo = ($urandom_range(0, 3) == 0) ? 0 : TW'($urandom_range(1, 15));
            mon_valid = $urandom_range(0, 1) == 1;
            mon_write = $urandom_range(0, 3) != 0;
            sel = $urandom_range(0, 7);
            case (sel)
                4:       mon_addr = BASE + 48'd1;
                5:       mon_addr = BASE + 48'h10;
                6:       mon_addr = BASE - 48'd4;
                7:       mon_addr = {16'h0, $urandom()};
                default: mon_addr = BASE + AW'(sel * 4);
            endcase
            mon_wdata = $urandom();
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
